// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types and default sizing for the project-select controller.
package mux_sel_ctrl_pkg;

  localparam int NUM_PROJECTS_DEF = 20;
  localparam int ADDR_W_DEF       = 5;
  localparam int GUARD_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_ON,
    ST_DROP
  } state_e;

  // Address update waiting to be applied once ena is low.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_INC,
    PEND_CLR
  } pend_e;

endpackage

// File: rtl/mux_sel_ctrl_sync.sv
// Multi-flop synchronizer for one asynchronous control pin, with a selectable reset value.
module mux_sel_ctrl_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mux_sel_ctrl.sv
// Break-before-make project select controller: ena is always dropped and a guard
// window inserted before addr is allowed to move.
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int NUM_PROJECTS = NUM_PROJECTS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_ena,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_sel_rst_n,
  output logic [ADDR_W-1:0] addr,
  output logic              ena,
  output logic              busy
);

  localparam logic [3:0] GUARD_RELOAD = 4'(GUARD_CYCLES - 1);

  logic ena_s, inc_s, srst_n_s;
  logic inc_prev_q, srst_prev_q;
  logic inc_evt, guard_hold;

  state_e            state_q;
  pend_e             pend_q;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [3:0]        guard_cnt_q;
  logic              ena_q, busy_q;

  mux_sel_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
    .clk(clk), .rst_n(rst_n), .d_i(ctrl_ena), .q_o(ena_s)
  );
  mux_sel_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_inc (
    .clk(clk), .rst_n(rst_n), .d_i(ctrl_sel_inc), .q_o(inc_s)
  );
  mux_sel_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_srst (
    .clk(clk), .rst_n(rst_n), .d_i(ctrl_sel_rst_n), .q_o(srst_n_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_prev_q  <= 1'b0;
      srst_prev_q <= 1'b1;
    end else begin
      inc_prev_q  <= inc_s;
      srst_prev_q <= srst_n_s;
    end
  end

  assign inc_evt    = inc_s & ~inc_prev_q;
  assign addr_nxt   = (addr_q == ADDR_W'(NUM_PROJECTS - 1)) ? '0 : addr_q + ADDR_W'(1);
  // The cycle in which srst_n_s returns high still reloads the guard, so the
  // select-reset recovery gives the same GUARD_CYCLES+1 ena latency as power-on enable.
  assign guard_hold = ~srst_n_s | ~srst_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      pend_q      <= PEND_NONE;
      addr_q      <= '0;
      guard_cnt_q <= '0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          pend_q <= PEND_NONE;
          if (!srst_n_s)                       addr_q <= '0;
          else if (inc_evt || pend_q == PEND_INC) addr_q <= addr_nxt;
          if (ena_s) begin
            state_q     <= ST_GUARD;
            guard_cnt_q <= GUARD_RELOAD;
            busy_q      <= 1'b1;
          end
        end

        ST_GUARD: begin
          if (!srst_n_s)    addr_q <= '0;
          else if (inc_evt) addr_q <= addr_nxt;
          if (!ena_s) begin
            state_q <= ST_OFF;
            busy_q  <= 1'b0;
          end else if (guard_hold || inc_evt) begin
            guard_cnt_q <= GUARD_RELOAD;
          end else if (guard_cnt_q == '0) begin
            state_q <= ST_ON;
            busy_q  <= 1'b0;
            ena_q   <= 1'b1;
          end else begin
            guard_cnt_q <= guard_cnt_q - 4'd1;
          end
        end

        ST_ON: begin
          if (!ena_s) begin
            state_q <= ST_OFF;
            ena_q   <= 1'b0;
            pend_q  <= (inc_evt && srst_n_s) ? PEND_INC : PEND_NONE;
          end else if (!srst_n_s || inc_evt) begin
            state_q <= ST_DROP;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
            pend_q  <= !srst_n_s ? PEND_CLR : PEND_INC;
          end
        end

        ST_DROP: begin
          if (!srst_n_s || pend_q == PEND_CLR) addr_q <= '0;
          else if (pend_q == PEND_INC)         addr_q <= addr_nxt;
          pend_q      <= PEND_NONE;
          state_q     <= ST_GUARD;
          guard_cnt_q <= GUARD_RELOAD;
        end

        default: begin
          state_q <= ST_OFF;
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr = addr_q;
  assign ena  = ena_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Scoreboard bench: operations predict timed addr/ena events; a negedge monitor checks them.
module tb_mux_sel_ctrl;

  localparam int N      = 20;
  localparam int AW     = 5;
  localparam int G      = 4;
  localparam int S      = 2;
  localparam int SETTLE = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ctrl_ena = 1'b0;
  logic          ctrl_sel_inc = 1'b0;
  logic          ctrl_sel_rst_n = 1'b1;
  logic [AW-1:0] addr;
  logic          ena;
  logic          busy;

  typedef struct {
    bit is_ena;
    int val;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_addr = 0;
  bit   m_on = 1'b0;

  logic [AW-1:0] last_addr = '0;
  logic          last_ena = 1'b0;

  mux_sel_ctrl #(
    .NUM_PROJECTS(N), .ADDR_W(AW), .GUARD_CYCLES(G), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_ena(ctrl_ena), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .addr(addr), .ena(ena), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input bit is_ena, input int val, input int at);
    exp_t e;
    e.is_ena = is_ena;
    e.val    = val;
    e.at     = at;
    exp_q.push_back(e);
  endfunction

  task automatic check_evt(input bit is_ena, input int val);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, expected no change",
               is_ena ? "ena" : "addr", val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_ena != is_ena || e.val != val || e.at != cyc) begin
        n_fail++;
        $display("FAIL event: got %s=%0d at cycle %0d expected %s=%0d at cycle %0d",
                 is_ena ? "ena" : "addr", val, cyc, e.is_ena ? "ena" : "addr", e.val, e.at);
      end
    end
  endtask

  // Monitor: every output change must match the head of the expectation queue.
  always @(negedge clk) begin
    if (ena !== last_ena) check_evt(1'b1, int'(ena));
    if (addr !== last_addr) begin
      check_evt(1'b0, int'(addr));
      check("addr_change_with_ena_high", int'(ena), 0);
    end
    last_ena  = ena;
    last_addr = addr;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_op(input int t0);
    wait_cyc(t0 + SETTLE);
    check("settled_ena", int'(ena), int'(m_on));
    check("settled_addr", int'(addr), m_addr);
    check("settled_busy", int'(busy), 0);
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic op_enable(input bit v);
    int t;
    t = cyc;
    if (v && !m_on)      push(1'b1, 1, t + S + G + 1);
    else if (!v && m_on) push(1'b1, 0, t + S + 1);
    m_on     = v;
    ctrl_ena = v;
    finish_op(t);
  endtask

  task automatic op_inc(input int w);
    int t, nxt;
    bit was_on;
    t      = cyc;
    was_on = m_on;
    nxt    = (m_addr + 1) % N;
    if (was_on) begin
      push(1'b1, 0, t + S + 1);
      push(1'b0, nxt, t + S + 2);
      push(1'b1, 1, t + S + 2 + G);
    end else begin
      push(1'b0, nxt, t + S + 1);
    end
    m_addr = nxt;
    ctrl_sel_inc = 1'b1;
    wait_cyc(t + w);
    ctrl_sel_inc = 1'b0;
    if (was_on) begin
      wait_cyc(t + S + 2);
      check("busy_in_guard", int'(busy), 1);
    end
    finish_op(t);
  endtask

  task automatic op_srst(input int len, input bit with_inc);
    int t;
    t = cyc;
    if (m_on) begin
      push(1'b1, 0, t + S + 1);
      if (m_addr != 0) push(1'b0, 0, t + S + 2);
      push(1'b1, 1, t + len + S + G + 1);
    end else if (m_addr != 0) begin
      push(1'b0, 0, t + S + 1);
    end
    ctrl_sel_rst_n = 1'b0;
    ctrl_sel_inc   = with_inc;
    wait_cyc(t + len);
    if (m_on) check("busy_while_srst", int'(busy), 1);
    check("ena_while_srst", int'(ena), 0);
    check("addr_while_srst", int'(addr), 0);
    m_addr = 0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    finish_op(t);
  endtask

  task automatic op_off_inc();
    int t, nxt;
    t   = cyc;
    nxt = (m_addr + 1) % N;
    push(1'b1, 0, t + S + 1);
    push(1'b0, nxt, t + S + 2);
    m_on   = 1'b0;
    m_addr = nxt;
    ctrl_ena     = 1'b0;
    ctrl_sel_inc = 1'b1;
    wait_cyc(t + 2);
    ctrl_sel_inc = 1'b0;
    finish_op(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected bench to finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    #1 rst_n = 1'b0;
    #1;
    check("reset_addr", int'(addr), 0);
    check("reset_ena", int'(ena), 0);
    check("reset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op_enable(1'b1);
    for (int i = 0; i < 3; i++) op_inc(4);
    check("three_steps_addr", int'(addr), 3);

    op_srst(6, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      op_inc(int'($urandom_range(1, 4)));
      if (i == 19) check("addr_after_19", int'(addr), 19);
      if (i == 20) check("addr_after_wrap", int'(addr), 0);
    end

    for (int i = 0; i < 5; i++) op_inc(2);
    op_srst(10, 1'b0);

    for (int i = 0; i < 7; i++) op_inc(1);
    op_srst(4, 1'b1);

    op_inc(3);
    op_off_inc();
    op_inc(2);
    op_inc(4);
    op_srst(5, 1'b0);
    op_inc(1);
    op_srst(6, 1'b1);
    op_enable(1'b1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       op_enable(!m_on);
        1, 2:    op_inc(int'($urandom_range(1, 4)));
        3:       op_srst(int'($urandom_range(4, 10)), 1'b0);
        4:       op_srst(int'($urandom_range(4, 10)), 1'b1);
        default: if (m_on) op_off_inc(); else op_inc(1);
      endcase
    end

    // Reset during the guard window.
    if (m_on) op_enable(1'b0);
    if (m_addr == 0) op_inc(1);
    t = cyc;
    ctrl_ena = 1'b1;
    wait_cyc(t + S + 2);
    check("busy_before_rst", int'(busy), 1);
    push(1'b0, 0, cyc);
    rst_n = 1'b0;
    #1;
    check("rst_guard_addr", int'(addr), 0);
    check("rst_guard_ena", int'(ena), 0);
    check("rst_guard_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    t = cyc;
    m_addr = 0;
    m_on   = 1'b1;
    push(1'b1, 1, t + S + G + 1);
    check("release_busy", int'(busy), 0);
    wait_cyc(t + S);
    check("release_still_off", int'(busy), 0);
    finish_op(t);

    // Reset while a step is pending in DROP must discard the step.
    t = cyc;
    push(1'b1, 0, t + S + 1);
    ctrl_sel_inc = 1'b1;
    wait_cyc(t + S + 1);
    if (m_addr != 0) push(1'b0, 0, cyc);
    rst_n = 1'b0;
    #1;
    check("rst_drop_addr", int'(addr), 0);
    check("rst_drop_busy", int'(busy), 0);
    ctrl_sel_inc = 1'b0;
    ctrl_ena     = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    t = cyc;
    m_on   = 1'b0;
    m_addr = 0;
    finish_op(t);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
